// File: rtl/pwm_compare_exp_2_pkg.sv
// Shared types and helpers for the PWM compare stage that follows the
// power-of-2 up/down counter.
package pwm_compare_exp_2_pkg;

    typedef enum logic [1:0] {
        DISABLED = 2'd0,
        ARMED    = 2'd1,
        RUNNING  = 2'd2
    } pwm_state_t;

    localparam int MAX_EXPONENT = 16;

    // Largest count value of a 2^exponent counter, i.e. 2^exponent - 1.
    function automatic logic [15:0] max_count(input int exponent);
        return 16'((32'd1 << exponent) - 32'd1);
    endfunction

    // Clamp a requested duty to the full period (2^exponent counts).
    function automatic logic [16:0] saturate_duty(input logic [16:0] duty,
                                                  input int          exponent);
        logic [16:0] full_scale;
        full_scale = 17'(32'd1 << exponent);
        return (duty > full_scale) ? full_scale : duty;
    endfunction

endpackage

// File: rtl/wrap_detect_exp_2.sv
// Two-stage sampler of the counter value and direction, flagging the cycle
// where the sampled count crosses the period boundary in its own direction.
module wrap_detect_exp_2
    import pwm_compare_exp_2_pkg::*;
#(
    parameter int EXPONENT = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [EXPONENT-1:0] count,
    input  logic                up,
    output logic [EXPONENT-1:0] s1,
    output logic                wrap
);

    localparam logic [EXPONENT-1:0] CNT_MAX = EXPONENT'(max_count(EXPONENT));

    logic [EXPONENT-1:0] s2;
    logic                up_q;

    // Capture the counter every edge; downstream logic only sees these copies.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1   <= '0;
            s2   <= '0;
            up_q <= 1'b1;
        end else begin
            s1   <= count;
            s2   <= s1;
            up_q <= up;
        end
    end

    // A boundary is only the natural roll-over in the sampled direction;
    // presets, counter resets and stalls never qualify.
    always_comb begin
        wrap = 1'b0;
        if (up_q) begin
            wrap = (s2 == CNT_MAX) && (s1 == '0);
        end else begin
            wrap = (s2 == '0) && (s1 == CNT_MAX);
        end
    end

endmodule

// File: rtl/pwm_compare_exp_2.sv
// PWM generator driven by an external power-of-2 counter. Duty requests are
// staged in a shadow register and applied only at a period boundary.
module pwm_compare_exp_2
    import pwm_compare_exp_2_pkg::*;
#(
    parameter int EXPONENT = 4
) (
    input  logic                i_CLOCK_POS,
    input  logic                i_RESET_NEG,
    input  logic [EXPONENT-1:0] i_VECTOR_COUNT,
    input  logic                i_BIT_UP,
    input  logic                i_BIT_ENABLE,
    input  logic [EXPONENT:0]   i_VECTOR_DUTY,
    input  logic                i_BIT_LOAD,
    output logic                o_BIT_PWM,
    output logic                o_BIT_WRAP,
    output logic                o_BIT_PENDING,
    output logic                o_BIT_LOAD_ACK
);

    logic [EXPONENT-1:0] s1;
    logic                wrap_c;

    logic [EXPONENT:0]   duty_sat;
    logic [EXPONENT:0]   shadow;
    logic [EXPONENT:0]   active;
    logic [EXPONENT:0]   active_next;
    logic                pending;
    logic                transfer;
    logic                pwm_cmp;

    pwm_state_t          state;
    logic                pwm_q;
    logic                wrap_q;
    logic                ack_q;

    wrap_detect_exp_2 #(
        .EXPONENT (EXPONENT)
    ) u_wrap_detect (
        .clk   (i_CLOCK_POS),
        .rst_n (i_RESET_NEG),
        .count (i_VECTOR_COUNT),
        .up    (i_BIT_UP),
        .s1    (s1),
        .wrap  (wrap_c)
    );

    // Duty clamp, shadow-to-active hand-off and the compare against the
    // duty that will be in force after this edge.
    always_comb begin
        duty_sat    = (EXPONENT+1)'(saturate_duty(17'(i_VECTOR_DUTY), EXPONENT));
        transfer    = wrap_c && pending;
        active_next = transfer ? shadow : active;
        pwm_cmp     = ({1'b0, s1} < active_next);
    end

    // Shadow/active duty registers plus the wrap and acknowledge pulses.
    always_ff @(posedge i_CLOCK_POS or negedge i_RESET_NEG) begin
        if (!i_RESET_NEG) begin
            shadow  <= '0;
            active  <= '0;
            pending <= 1'b0;
            wrap_q  <= 1'b0;
            ack_q   <= 1'b0;
        end else begin
            wrap_q <= wrap_c;
            ack_q  <= transfer;
            active <= active_next;
            if (i_BIT_LOAD) begin
                shadow  <= duty_sat;
                pending <= 1'b1;
            end else if (transfer) begin
                pending <= 1'b0;
            end
        end
    end

    // Enable/alignment state machine with a registered PWM output; the edge
    // that enters RUNNING already produces a compared PWM value.
    always_ff @(posedge i_CLOCK_POS or negedge i_RESET_NEG) begin
        if (!i_RESET_NEG) begin
            state <= DISABLED;
            pwm_q <= 1'b0;
        end else begin
            case (state)
                DISABLED: begin
                    pwm_q <= 1'b0;
                    if (i_BIT_ENABLE) begin
                        state <= ARMED;
                    end
                end
                ARMED: begin
                    if (!i_BIT_ENABLE) begin
                        state <= DISABLED;
                        pwm_q <= 1'b0;
                    end else if (wrap_c) begin
                        state <= RUNNING;
                        pwm_q <= pwm_cmp;
                    end else begin
                        pwm_q <= 1'b0;
                    end
                end
                RUNNING: begin
                    if (!i_BIT_ENABLE) begin
                        state <= DISABLED;
                        pwm_q <= 1'b0;
                    end else begin
                        pwm_q <= pwm_cmp;
                    end
                end
                default: begin
                    state <= DISABLED;
                    pwm_q <= 1'b0;
                end
            endcase
        end
    end

    assign o_BIT_PWM      = pwm_q;
    assign o_BIT_WRAP     = wrap_q;
    assign o_BIT_PENDING  = pending;
    assign o_BIT_LOAD_ACK = ack_q;

endmodule

// File: tb/tb_pwm_compare_exp_2.sv
// Scoreboard bench for pwm_compare_exp_2: the stimulus process queues the
// output word expected after each edge, and a monitor compares on negedges.
module tb_pwm_compare_exp_2;

    localparam int EXPONENT = 4;

    logic                clock = 1'b0;
    logic                resetN;
    logic [EXPONENT-1:0] vectorCount;
    logic                bitUp;
    logic                bitEnable;
    logic [EXPONENT:0]   vectorDuty;
    logic                bitLoad;
    logic                pwmOut;
    logic                wrapOut;
    logic                pendingOut;
    logic                loadAckOut;

    typedef struct {
        int         atEdge;
        logic [3:0] expVal;
        int         scen;
        int         step;
    } expect_t;

    expect_t expectQ[$];
    int      edgeCount   = 0;
    int      testsRun    = 0;
    int      testsFailed = 0;

    pwm_compare_exp_2 #(
        .EXPONENT (EXPONENT)
    ) dut (
        .i_CLOCK_POS    (clock),
        .i_RESET_NEG    (resetN),
        .i_VECTOR_COUNT (vectorCount),
        .i_BIT_UP       (bitUp),
        .i_BIT_ENABLE   (bitEnable),
        .i_VECTOR_DUTY  (vectorDuty),
        .i_BIT_LOAD     (bitLoad),
        .o_BIT_PWM      (pwmOut),
        .o_BIT_WRAP     (wrapOut),
        .o_BIT_PENDING  (pendingOut),
        .o_BIT_LOAD_ACK (loadAckOut)
    );

    // Free-running clock, period 10.
    always #5 clock = ~clock;

    // Edge counter used to tag each expectation with the edge it belongs to.
    always @(posedge clock) edgeCount <= edgeCount + 1;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    // Drives one edge worth of inputs (called in the low clock phase) and
    // queues the {pwm, wrap, pending, ack} word expected after that edge.
    task automatic applyStimulus(input logic [3:0] count, input logic up,
                                 input logic enable, input logic [4:0] duty,
                                 input logic load, input logic [3:0] expVal,
                                 input int scen, input int step);
        expect_t e;
        vectorCount = count;
        bitUp       = up;
        bitEnable   = enable;
        vectorDuty  = duty;
        bitLoad     = load;
        e.atEdge = edgeCount + 1;
        e.expVal = expVal;
        e.scen   = scen;
        e.step   = step;
        expectQ.push_back(e);
        @(negedge clock);
    endtask

    task automatic doReset(input string name);
        #2;
        resetN      = 1'b0;
        vectorCount = '0;
        bitUp       = 1'b1;
        bitEnable   = 1'b0;
        vectorDuty  = '0;
        bitLoad     = 1'b0;
        #1;
        checkOutput(name, {28'd0, pwmOut, wrapOut, pendingOut, loadAckOut}, 32'd0);
        @(negedge clock);
        @(negedge clock);
        #2;
        resetN = 1'b1;
    endtask

    // Monitor: compares every queued expectation whose edge has just passed.
    initial begin
        forever begin
            @(negedge clock);
            #1;
            for (int i = expectQ.size() - 1; i >= 0; i--) begin
                if (expectQ[i].atEdge == edgeCount) begin
                    checkOutput($sformatf("s%0d_t%0d", expectQ[i].scen, expectQ[i].step),
                                {28'd0, pwmOut, wrapOut, pendingOut, loadAckOut},
                                {28'd0, expectQ[i].expVal});
                    expectQ.delete(i);
                end
            end
        end
    end

    // Watchdog so the run always ends.
    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] timeout");
    end

    // Directed scenarios; expected words are derived from the count sequence.
    initial begin
        logic       ePwm, eWrap, ePend, eAck;
        logic [4:0] duty;

        resetN = 1'b0;

        // 1: up count, duty 4 loaded while ARMED; first wrap starts RUNNING.
        doReset("reset_s1");
        for (int t = 1; t <= 49; t++) begin
            ePwm  = (t >= 18) && (((t - 2) % 16) < 4);
            eWrap = (t >= 18) && (((t - 2) % 16) == 0);
            ePend = (t >= 3) && (t < 18);
            eAck  = (t == 18);
            applyStimulus(4'((t - 1) % 16), 1'b1, 1'b1, 5'd4, t == 3,
                          {ePwm, eWrap, ePend, eAck}, 1, t);
        end

        // 2: duty 0, then 16, then 20 (saturates to 16).
        doReset("reset_s2");
        for (int t = 1; t <= 60; t++) begin
            duty  = (t == 20) ? 5'd16 : (t == 36) ? 5'd20 : 5'd0;
            ePwm  = (t >= 34);
            eWrap = (t >= 18) && (((t - 2) % 16) == 0);
            ePend = ((t >= 3) && (t < 18)) || ((t >= 20) && (t < 34)) || ((t >= 36) && (t < 50));
            eAck  = (t == 18) || (t == 34) || (t == 50);
            applyStimulus(4'((t - 1) % 16), 1'b1, 1'b1, duty,
                          (t == 3) || (t == 20) || (t == 36),
                          {ePwm, eWrap, ePend, eAck}, 2, t);
        end

        // 3: load 8 then 3 before the wrap; only 3 is ever applied.
        doReset("reset_s3");
        for (int t = 1; t <= 52; t++) begin
            duty  = (t == 20) ? 5'd8 : 5'd3;
            ePwm  = (t >= 34) && (((t - 2) % 16) < 3);
            eWrap = (t >= 18) && (((t - 2) % 16) == 0);
            ePend = (t >= 20) && (t < 34);
            eAck  = (t == 34);
            applyStimulus(4'((t - 1) % 16), 1'b1, 1'b1, duty,
                          (t == 20) || (t == 25),
                          {ePwm, eWrap, ePend, eAck}, 3, t);
        end

        // 4: load 5 on the wrap edge while 9 is pending.
        doReset("reset_s4");
        for (int t = 1; t <= 52; t++) begin
            duty  = (t == 3) ? 5'd9 : 5'd5;
            if (t >= 34)      ePwm = (((t - 2) % 16) < 5);
            else if (t >= 18) ePwm = (((t - 2) % 16) < 9);
            else              ePwm = 1'b0;
            eWrap = (t >= 18) && (((t - 2) % 16) == 0);
            ePend = (t >= 3) && (t < 34);
            eAck  = (t == 18) || (t == 34);
            applyStimulus(4'((t - 1) % 16), 1'b1, 1'b1, duty,
                          (t == 3) || (t == 18),
                          {ePwm, eWrap, ePend, eAck}, 4, t);
        end

        // 5: down count with duty 6, then a preset jump 7->12 while disabled.
        doReset("reset_s5");
        for (int t = 1; t <= 44; t++) begin
            ePwm  = (t >= 17) && (((16 - t) & 15) <= 5);
            eWrap = (t == 17) || (t == 33);
            ePend = (t >= 3) && (t < 17);
            eAck  = (t == 17);
            applyStimulus(4'((15 - t) & 15), 1'b0, 1'b1, 5'd6, t == 3,
                          {ePwm, eWrap, ePend, eAck}, 5, t);
        end
        applyStimulus(4'd7,  1'b0, 1'b0, 5'd6, 1'b0, 4'b0000, 5, 45);
        applyStimulus(4'd12, 1'b0, 1'b0, 5'd6, 1'b0, 4'b0000, 5, 46);
        applyStimulus(4'd11, 1'b0, 1'b0, 5'd6, 1'b0, 4'b0000, 5, 47);
        applyStimulus(4'd10, 1'b0, 1'b0, 5'd6, 1'b0, 4'b0000, 5, 48);

        // 6: reset while RUNNING with a pending duty; re-arm needs a wrap.
        doReset("reset_s6");
        for (int t = 1; t <= 20; t++) begin
            duty  = (t == 19) ? 5'd7 : 5'd4;
            ePwm  = (t >= 18) && (((t - 2) % 16) < 4);
            eWrap = (t == 18);
            ePend = ((t >= 3) && (t < 18)) || (t >= 19);
            eAck  = (t == 18);
            applyStimulus(4'((t - 1) % 16), 1'b1, 1'b1, duty,
                          (t == 3) || (t == 19),
                          {ePwm, eWrap, ePend, eAck}, 6, t);
        end
        #2;
        resetN = 1'b0;
        #1;
        checkOutput("midrun_reset", {28'd0, pwmOut, wrapOut, pendingOut, loadAckOut}, 32'd0);
        #1;
        resetN = 1'b1;
        for (int t = 21; t <= 40; t++) begin
            ePwm  = (t >= 34) && (((t - 2) % 16) < 4);
            eWrap = (t == 34);
            ePend = (t >= 23) && (t < 34);
            eAck  = (t == 34);
            applyStimulus(4'((t - 1) % 16), 1'b1, 1'b1, 5'd4, t == 23,
                          {ePwm, eWrap, ePend, eAck}, 6, t);
        end

        repeat (2) @(negedge clock);
        #2;
        checkOutput("queue_drained", 32'(expectQ.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule

// File: doc/pwm_compare_exp_2.md
Name: pwm_compare_exp_2

Overview:
- Downstream consumer of the power-of-2 up/down counter.
- Samples the counter's count vector and generates a PWM output whose duty is compared against that count.
- Duty updates go through a shadow register and take effect only at a period boundary (counter wrap), giving glitch-free duty changes.
- Also publishes a one-cycle wrap pulse for other stages.

Parameters:
- EXPONENT, 4: counter width in bits; period = 2^EXPONENT counts. Legal range 2..16.

Ports:
- i_CLOCK_POS  input  1  system clock, rising edge; same clock that drives the counter.
- i_RESET_NEG  input  1  reset, asynchronous, active-low.
- i_VECTOR_COUNT  input  EXPONENT  counter output value.
- i_BIT_UP  input  1  counter direction: 1 = up, 0 = down.
- i_BIT_ENABLE  input  1  level enable for PWM generation.
- i_VECTOR_DUTY  input  EXPONENT+1  requested duty in counts, 0..2^EXPONENT; larger values saturate to 2^EXPONENT.
- i_BIT_LOAD  input  1  one-cycle strobe; captures i_VECTOR_DUTY into the shadow register.
- o_BIT_PWM  output  1  registered PWM output.
- o_BIT_WRAP  output  1  one-cycle pulse per detected period boundary.
- o_BIT_PENDING  output  1  shadow holds a duty value not yet applied.
- o_BIT_LOAD_ACK  output  1  one-cycle pulse when shadow is transferred to active.

Behaviour:
- Reset (async, i_RESET_NEG=0): all outputs 0; sample registers s1/s2 = 0; shadow = 0; active = 0; up_q = 1; state = DISABLED.
- Sampling:
  - s1 <= i_VECTOR_COUNT, up_q <= i_BIT_UP, s2 <= s1, every edge.
  - All decisions use s1/s2/up_q only, never raw inputs.
- Wrap (combinational, wrap_c):
  - up_q=1: s2 == 2^EXPONENT-1 and s1 == 0.
  - up_q=0: s2 == 0 and s1 == 2^EXPONENT-1.
  - Any other jump (preset, reset of counter, stall) is not a wrap.
  - o_BIT_WRAP <= wrap_c. Pulse appears 2 edges after the wrapped count is presented.
- Shadow/load:
  - On an edge with i_BIT_LOAD=1: shadow <= saturated duty, pending <= 1.
  - On an edge with wrap_c=1 and pending=1: active <= shadow, o_BIT_LOAD_ACK <= 1 for one cycle, pending <= 0.
  - Load coincident with a pending wrap: the old shadow goes to active, the new value goes to shadow, pending stays 1, ack pulses.
  - Load while pending with no wrap: last value wins, no ack.
  - Wrap with pending=0: active unchanged, no ack.
  - Transfers happen in every state, including DISABLED.
- active_next = value active takes on this edge (shadow if wrap_c and pending, else active).
- State machine:
  - DISABLED: o_BIT_PWM <= 0. Goes to ARMED when i_BIT_ENABLE=1.
  - ARMED: o_BIT_PWM <= 0. Waits for period alignment; goes to RUNNING on an edge with wrap_c=1. That same edge already drives PWM per the RUNNING rule.
  - RUNNING: o_BIT_PWM <= (s1 < active_next), unsigned, EXPONENT+1-bit compare.
  - ARMED or RUNNING goes to DISABLED on any edge with i_BIT_ENABLE=0; o_BIT_PWM <= 0 on that edge.
- Duty boundaries:
  - 0 gives constant low.
  - 2^EXPONENT gives constant high.
  - Up mode: high for the first duty counts of the period. Down mode: high for the last duty counts.
- PWM latency: count presented at edge n gives PWM at edge n+1 (s1 valid) and is compared at edge n+2.
- Reset mid-operation: immediate return to the reset values above; any pending duty is lost.
- Direction change mid-period: no wrap is inferred from the change itself. Wrap detection follows up_q.

Decomposition:
- Package pwm_compare_exp_2_pkg holds:
  - State encoding localparams DISABLED=2'd0, ARMED=2'd1, RUNNING=2'd2.
  - Helper constant for the max count, 2^EXPONENT-1.
  - Duty saturation function.
- One natural sub-module, wrap_detect_exp_2: owns s1, s2, up_q and wrap_c; outputs s1 and wrap_c.
- The top level holds the shadow/active registers, the FSM and the output registers.

Test Plan:
- Reset then enable, up count 0..15 repeating, load duty 4 during ARMED: first wrap (s2=15, s1=0) gives ack pulse and RUNNING. PWM is high for exactly 4 of every 16 cycles, starting 2 cycles after count 0 is presented.
- Duty 0, then duty 16, then load duty 20: PWM constant 0, then constant 1; the 20 saturates to 16 and PWM stays constant 1.
- Load 8, then load 3 before the next wrap: at the wrap active=3, a single ack, pending 1→0. The value 8 is never applied.
- Load 5 on the same edge as wrap_c with shadow=9 pending: active=9, shadow=5, pending stays 1, ack=1. At the next wrap active=5 and a second ack pulses.
- Down count 15..0, duty 6: wrap on 0→15. PWM high while s1 is 5..0 (last 6 counts). A counter preset jump 7→12 produces no o_BIT_WRAP.
- Deassert i_RESET_NEG mid-RUNNING with pending=1: all outputs 0 asynchronously, pending 0. After release the block needs enable plus a wrap before PWM resumes.
